// File: rtl/simon_pkg.sv
// SIMON key-schedule constants: z sequences, round counts and z selection per (n,m) pair.
package simon_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ks_state_e;

  // The sequences are written in element order (element 0 leftmost); rev62 puts element i at bit i.
  function automatic logic [61:0] rev62(input logic [61:0] s);
    logic [61:0] r;
    for (int i = 0; i < 62; i++) r[i] = s[61-i];
    return r;
  endfunction

  localparam logic [61:0] Z0 = rev62(62'b11111010001001010110000111001101111101000100101011000011100110);
  localparam logic [61:0] Z1 = rev62(62'b10001110111110010011000010110101000111011111001001100001011010);
  localparam logic [61:0] Z2 = rev62(62'b10101111011100000011010010011000101000010001111110010110110011);
  localparam logic [61:0] Z3 = rev62(62'b11011011101011000110010111100000010010001010011100110100001111);
  localparam logic [61:0] Z4 = rev62(62'b11010001111001101011011000100000010111000011001010010011101111);

  // Zero marks an (n,m) pair outside the SIMON family.
  function automatic int simon_rounds(input int n, input int m);
    if (n == 16 && m == 4) return 32;
    if (n == 24 && m == 3) return 36;
    if (n == 24 && m == 4) return 36;
    if (n == 32 && m == 3) return 42;
    if (n == 32 && m == 4) return 44;
    if (n == 48 && m == 2) return 52;
    if (n == 48 && m == 3) return 54;
    if (n == 64 && m == 2) return 68;
    if (n == 64 && m == 3) return 69;
    if (n == 64 && m == 4) return 72;
    return 0;
  endfunction

  function automatic int simon_zsel(input int n, input int m);
    if (n == 16 && m == 4) return 0;
    if (n == 24 && m == 3) return 0;
    if (n == 24 && m == 4) return 1;
    if (n == 32 && m == 3) return 2;
    if (n == 32 && m == 4) return 3;
    if (n == 48 && m == 2) return 2;
    if (n == 48 && m == 3) return 3;
    if (n == 64 && m == 2) return 2;
    if (n == 64 && m == 3) return 3;
    return 4;
  endfunction

  function automatic bit simon_legal(input int n, input int m);
    return simon_rounds(n, m) != 0;
  endfunction

  function automatic logic [61:0] simon_zseq(input int sel);
    case (sel)
      0:       return Z0;
      1:       return Z1;
      2:       return Z2;
      3:       return Z3;
      default: return Z4;
    endcase
  endfunction

endpackage

// File: rtl/simon_ks_step.sv
// Combinational SIMON key-schedule word update over an m-word window; the same
// expression yields k[i+m] from k[i] and, with the window mirrored, k[i] from k[i+m].
module simon_ks_step #(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4
) (
  input  logic [KEY_WORDS-1:0][WORD_W-1:0] win_i,
`ifdef SIMON_KS_REVERSE_EN
  input  logic                             rev_i,
`endif
  input  logic                             z_bit_i,
  output logic [WORD_W-1:0]                word_o
);

  logic [WORD_W-1:0] x, a, b, t;

  always_comb begin
    // x: word being replaced; a: k[i+m-1]; b: k[i+1]
    x = win_i[0];
    a = win_i[KEY_WORDS-1];
    b = win_i[1];
`ifdef SIMON_KS_REVERSE_EN
    if (rev_i) begin
      x = win_i[KEY_WORDS-1];
      a = win_i[KEY_WORDS-2];
      b = win_i[0];
    end
`endif
    t = {a[2:0], a[WORD_W-1:3]};
    if (KEY_WORDS == 4) t = t ^ b;
    word_o = ~x ^ t ^ {t[0], t[WORD_W-1:1]} ^ WORD_W'(z_bit_i) ^ WORD_W'(3);
  end

endmodule

// File: rtl/simon_key_expander.sv
// Sequential SIMON round-key generator streaming k[0..T-1] over valid/ready, one key per transfer.
// Defining SIMON_KS_REVERSE_EN adds a dir input that streams k[T-1..0] from the last m keys.
module simon_key_expander
  import simon_pkg::*;
#(
  parameter int  WORD_W    = 16,
  parameter int  KEY_WORDS = 4,
  localparam int ROUNDS    = simon_rounds(WORD_W, KEY_WORDS),
  localparam int Z_SEL     = simon_zsel(WORD_W, KEY_WORDS),
  localparam int IDX_W     = (ROUNDS < 2) ? 1 : $clog2(ROUNDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WORD_W*KEY_WORDS-1:0] key_in,
`ifdef SIMON_KS_REVERSE_EN
  input  logic                        dir,
`endif
  output logic                        rk_valid,
  input  logic                        rk_ready,
  output logic [WORD_W-1:0]           rk,
  output logic [IDX_W-1:0]            rk_idx,
  output logic                        busy,
  output logic                        done
);

  if (!simon_legal(WORD_W, KEY_WORDS)) begin : g_bad_cfg
    $error("simon_key_expander: illegal pair WORD_W=%0d KEY_WORDS=%0d", WORD_W, KEY_WORDS);
  end

  localparam logic [61:0]      Z_SEQ    = simon_zseq(Z_SEL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
  // Descending streams first need z[(T-1-m) mod 62] for the word below the window.
  localparam logic [5:0]       ZC_REV0  = 6'((ROUNDS - 1 - KEY_WORDS) % 62);

  ks_state_e                         state_q, state_d;
  logic [KEY_WORDS-1:0][WORD_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [5:0]                        zc_q, zc_d;
  logic [WORD_W-1:0]                 new_word;
  logic [IDX_W-1:0]                  final_idx;
  logic                              z_bit;
  logic                              rev;

`ifdef SIMON_KS_REVERSE_EN
  logic dir_q, dir_d;
  assign rev = dir_q;
`else
  assign rev = 1'b0;
`endif

  assign z_bit     = Z_SEQ[zc_q];
  assign final_idx = rev ? '0 : LAST_IDX;

  simon_ks_step #(
    .WORD_W    (WORD_W),
    .KEY_WORDS (KEY_WORDS)
  ) u_step (
    .win_i   (win_q),
`ifdef SIMON_KS_REVERSE_EN
    .rev_i   (dir_q),
`endif
    .z_bit_i (z_bit),
    .word_o  (new_word)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    zc_d    = zc_q;
    done    = 1'b0;
`ifdef SIMON_KS_REVERSE_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EMIT;
          win_d   = key_in;
          idx_d   = '0;
          zc_d    = '0;
`ifdef SIMON_KS_REVERSE_EN
          dir_d   = dir;
          if (dir) begin
            idx_d = LAST_IDX;
            zc_d  = ZC_REV0;
          end
`endif
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (idx_q == final_idx) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else if (rev) begin
            win_d = {win_q[KEY_WORDS-2:0], new_word};
            idx_d = idx_q - 1'b1;
            zc_d  = (zc_q == 6'd0) ? 6'd61 : zc_q - 6'd1;
          end else begin
            win_d = {new_word, win_q[KEY_WORDS-1:1]};
            idx_d = idx_q + 1'b1;
            zc_d  = (zc_q == 6'd61) ? 6'd0 : zc_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      idx_q   <= '0;
      zc_q    <= '0;
`ifdef SIMON_KS_REVERSE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      zc_q    <= zc_d;
`ifdef SIMON_KS_REVERSE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign rk_valid = (state_q == ST_EMIT);
  assign busy     = (state_q == ST_EMIT);
  assign rk       = rev ? win_q[KEY_WORDS-1] : win_q[0];
  assign rk_idx   = idx_q;

endmodule

// File: tb/tb_simon_key_expander.sv
// Bench for simon_key_expander: SIMON32/64 directed/random runs plus a sweep of every legal (n,m) pair.
module tb_simon_key_expander;

  typedef logic [63:0] karr_t [72];

  localparam int CFG_N [10] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
  localparam int CFG_M [10] = '{ 4,  3,  4,  3,  4,  2,  3,  2,  3,  4};
  localparam int CFG_T [10] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
  localparam int CFG_Z [10] = '{ 0,  0,  1,  2,  3,  2,  3,  2,  3,  4};

  // Element i of sequence s is ZB[s][61-i] (strings as printed in the SIMON paper).
  localparam logic [61:0] ZB [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111};

  localparam logic [63:0] GOLD = 64'h1918_1110_0908_0100;

  logic        clk, rst_n, start, rk_ready, rk_valid, busy, done;
  logic [63:0] key_in;
  logic [15:0] rk;
  logic [4:0]  rk_idx;
`ifdef SIMON_KS_REVERSE_EN
  logic        dir;
`endif

  int total = 0;
  int bad = 0;
  bit sweep_go = 0;
  int sweep_done = 0;

  simon_key_expander #(.WORD_W(16), .KEY_WORDS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
`ifdef SIMON_KS_REVERSE_EN
    .dir(dir),
`endif
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx),
    .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Golden schedule: k[i+m] = ~k[i] ^ t ^ (t ror 1) ^ z[i] ^ 3, t = k[i+m-1] ror 3 (^ k[i+1] for m=4).
  function automatic void ks_model(input int n, input int m, input int zs,
                                   input logic [255:0] w, output karr_t k);
    logic [63:0] mask, t;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < 72; i++) k[i] = '0;
    for (int j = 0; j < m; j++) k[j] = w[j*64 +: 64] & mask;
    for (int i = m; i < 72; i++) begin
      t = ror(k[i-1], 3, n);
      if (m == 4) t = t ^ k[i-3];
      k[i] = (~k[i-m] ^ t ^ ror(t, 1, n) ^ 64'(ZB[zs][61 - ((i - m) % 62)]) ^ 64'd3) & mask;
    end
  endfunction

  // One full SIMON32/64 expansion on the main DUT; optional stalls, mid-run start pulse and reset.
  task automatic run_main(input logic [63:0] mkey, input bit rev, input int stall_pct,
                          input int start_at, input int reset_at);
    karr_t       kx;
    logic [255:0] w;
    int          cnt, e, fe;
    bit          fin;
    w = '0;
    for (int j = 0; j < 4; j++) w[j*64 +: 64] = 64'(mkey[j*16 +: 16]);
    ks_model(16, 4, 0, w, kx);
    fe = rev ? 0 : 31;
    key_in = rev ? {kx[31][15:0], kx[30][15:0], kx[29][15:0], kx[28][15:0]} : mkey;
`ifdef SIMON_KS_REVERSE_EN
    dir = rev;
`endif
    start = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    key_in = ~key_in;
    chk("first_vld", 64'(rk_valid), 64'd1);
    cnt = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      e = rev ? 31 - cnt : cnt;
      rk_ready = ($urandom_range(99) >= stall_pct);
      start = (start_at >= 0) && (cnt == start_at || e == fe);
      #1;
      chk("vld", 64'(rk_valid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("rk", 64'(rk), kx[e]);
      chk("rk_idx", 64'(rk_idx), 64'(e));
      chk("done", 64'(done), 64'(rk_ready && e == fe));
      if (mkey == GOLD && e == 4) chk("k4_lit", 64'(rk), 64'h71C3);
      if (mkey == GOLD && rev && e == 0) chk("rev_k0_lit", 64'(rk), 64'h0100);
      if (cnt == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_vld", 64'(rk_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rk", 64'(rk), 64'd0);
        chk("rst_idx", 64'(rk_idx), 64'd0);
        start = 1'b0;
        fin = 1'b1;
      end else if (rk_ready) begin
        if (e == fe) fin = 1'b1;
        cnt++;
      end
      @(negedge clk);
    end
    chk("main_finished", 64'(fin), 64'd1);
    if (reset_at >= 0) rst_n = 1'b1;
    else chk("main_count", 64'(cnt), 64'd32);
    chk("idle_vld", 64'(rk_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    start = 1'b0;
    rk_ready = 1'b0;
  endtask

  for (genvar g = 0; g < 10; g++) begin : g_sweep
    localparam int N  = CFG_N[g];
    localparam int M  = CFG_M[g];
    localparam int T  = CFG_T[g];
    localparam int IW = $clog2(T);
    logic           st, rdy, vld, bsy, dn;
    logic [N*M-1:0] kin;
    logic [N-1:0]   rko;
    logic [IW-1:0]  rki;

    simon_key_expander #(.WORD_W(N), .KEY_WORDS(M)) u_sw (
      .clk(clk), .rst_n(rst_n), .start(st), .key_in(kin),
`ifdef SIMON_KS_REVERSE_EN
      .dir(1'b0),
`endif
      .rk_valid(vld), .rk_ready(rdy), .rk(rko), .rk_idx(rki),
      .busy(bsy), .done(dn));

    initial begin : p_sweep
      karr_t        kx;
      logic [255:0] w;
      int           cnt;
      bit           fin;
      st = 1'b0;
      rdy = 1'b0;
      kin = '0;
      wait (sweep_go);
      for (int run = 0; run < 2; run++) begin
        @(negedge clk);
        w = '0;
        for (int j = 0; j < M; j++) begin
          kin[j*N +: N] = N'({$urandom(), $urandom()});
          w[j*64 +: 64] = 64'(kin[j*N +: N]);
        end
        ks_model(N, M, CFG_Z[g], w, kx);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        cnt = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
          rdy = ($urandom_range(1) == 1);
          #1;
          chk("sw_vld", 64'(vld), 64'd1);
          chk("sw_busy", 64'(bsy), 64'd1);
          chk("sw_rk", 64'(rko), kx[cnt]);
          chk("sw_idx", 64'(rki), 64'(cnt));
          chk("sw_done", 64'(dn), 64'(rdy && cnt == T - 1));
          if (rdy) begin
            if (cnt == T - 1) fin = 1'b1;
            cnt++;
          end
          @(negedge clk);
        end
        rdy = 1'b0;
        chk("sw_count", 64'(cnt), 64'(T));
        chk("sw_idle", 64'(vld), 64'd0);
      end
      sweep_done++;
    end
  end

  initial begin : p_main
    karr_t        kg;
    logic [255:0] wg;
    rst_n = 1'b0;
    start = 1'b0;
    rk_ready = 1'b0;
    key_in = '0;
`ifdef SIMON_KS_REVERSE_EN
    dir = 1'b0;
`endif
    wg = '0;
    for (int j = 0; j < 4; j++) wg[j*64 +: 64] = 64'(GOLD[j*16 +: 16]);
    ks_model(16, 4, 0, wg, kg);
    chk("model_k4", kg[4], 64'h71C3);
    chk("model_k0", kg[0], 64'h0100);
    repeat (2) @(negedge clk);
    chk("reset_vld", 64'(rk_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rk", 64'(rk), 64'd0);
    chk("reset_idx", 64'(rk_idx), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", 64'(rk_valid), 64'd0);

    run_main(GOLD, 1'b0, 0, -1, -1);
    run_main(GOLD, 1'b0, 0, 5, 10);
    run_main(GOLD, 1'b0, 50, 5, -1);
    run_main(GOLD, 1'b0, 0, -1, -1);
    for (int r = 0; r < 3; r++) run_main({$urandom(), $urandom()}, 1'b0, 50, 7, -1);
`ifdef SIMON_KS_REVERSE_EN
    run_main(GOLD, 1'b1, 0, -1, -1);
    run_main({$urandom(), $urandom()}, 1'b1, 50, 3, -1);
    run_main(GOLD, 1'b0, 30, -1, -1);
`endif

    sweep_go = 1'b1;
    for (int c = 0; c < 5000 && sweep_done < 10; c++) @(negedge clk);
    chk("sweep_all_done", 64'(sweep_done), 64'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : p_watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
